// File: rtl/pipe_pkg.sv
// Shared types and default widths for the inter-stage pipeline register.
// No logic; no latency; no backpressure.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int PIPE_CTRL_W = 7;
    localparam int PIPE_DATA_W = 16;

    // Saturating +1 for a counter of up to 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        sat_inc = (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// One valid+ctrl+data holding register; clear zeroes valid and ctrl, data holds.
// Latency: load visible one cycle later. No backpressure of its own.
module pipe_skid_entry
    import pipe_pkg::*;
#(
    parameter int CTRL_WIDTH    = PIPE_CTRL_W,
    parameter int PAYLOAD_WIDTH = 4 * PIPE_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_load,
    input  logic                     i_clear,
    input  logic [CTRL_WIDTH-1:0]    i_ctrl,
    input  logic [PAYLOAD_WIDTH-1:0] i_data,
    output logic                     o_valid,
    output logic [CTRL_WIDTH-1:0]    o_ctrl,
    output logic [PAYLOAD_WIDTH-1:0] o_data
);

    logic                     r_valid;
    logic [CTRL_WIDTH-1:0]    r_ctrl;
    logic [PAYLOAD_WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            // Bubble: ctrl forced to zero, data left alone.
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready, flush and stall counter; skid entry under PIPE_STAGE_SKID_EN.
// Latency: one cycle. Backpressure: registered in_ready (skid build) or in_ready = out_ready || empty.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_WIDTH = PIPE_CTRL_W,
    parameter int DATA_WIDTH = PIPE_DATA_W,
    parameter int NUM_FIELDS = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CTRL_WIDTH-1:0]            in_ctrl,
    input  logic [NUM_FIELDS*DATA_WIDTH-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic [NUM_FIELDS*DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]             stall_count
);

    localparam int PAYLOAD_W = NUM_FIELDS * DATA_WIDTH;

    pipe_state_t            r_state;
    logic [CNT_WIDTH-1:0]   r_stall_cnt;
    logic                   w_in_hs;
    logic                   w_out_hs;
    logic                   w_main_vld;
    logic                   w_main_load;
    logic                   w_main_clear;
    logic [CTRL_WIDTH-1:0]  w_main_ctrl;
    logic [PAYLOAD_W-1:0]   w_main_data;

    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = w_main_vld && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic                   r_in_rdy;
    logic                   w_skid_vld;
    logic                   w_skid_load;
    logic                   w_skid_clear;
    logic [CTRL_WIDTH-1:0]  w_skid_ctrl;
    logic [PAYLOAD_W-1:0]   w_skid_data;

    assign in_ready = r_in_rdy;

    always_comb begin
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        w_main_ctrl  = in_ctrl;
        w_main_data  = in_data;
        if (flush) begin
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            case (r_state)
                EMPTY: w_main_load = w_in_hs;
                BUSY: begin
                    if (w_out_hs) begin
                        w_main_load  = w_in_hs;
                        w_main_clear = !w_in_hs;
                    end else begin
                        w_skid_load  = w_in_hs;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the skid can refill main.
                    if (w_out_hs && w_skid_vld) begin
                        w_main_load  = 1'b1;
                        w_main_ctrl  = w_skid_ctrl;
                        w_main_data  = w_skid_data;
                        w_skid_clear = 1'b1;
                    end
                end
                default: begin
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state  <= EMPTY;
            r_in_rdy <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_hs) r_state <= BUSY;
                end
                BUSY: begin
                    if (w_out_hs && !w_in_hs) begin
                        r_state <= EMPTY;
                    end else if (!w_out_hs && w_in_hs) begin
                        r_state  <= FULL;
                        r_in_rdy <= 1'b0;
                    end
                end
                FULL: begin
                    if (w_out_hs) begin
                        r_state  <= BUSY;
                        r_in_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= EMPTY;
                    r_in_rdy <= 1'b1;
                end
            endcase
        end
    end

    pipe_skid_entry #(
        .CTRL_WIDTH    (CTRL_WIDTH),
        .PAYLOAD_WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_vld),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
    );
`else
    // Combinational ready: a full stage can still accept if it drains this cycle.
    assign in_ready    = out_ready || (r_state == EMPTY);
    assign w_main_ctrl = in_ctrl;
    assign w_main_data = in_data;

    always_comb begin
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        if (flush) begin
            w_main_clear = 1'b1;
        end else if (w_in_hs) begin
            w_main_load  = 1'b1;
        end else if (w_out_hs) begin
            w_main_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state <= EMPTY;
        end else if (w_in_hs) begin
            r_state <= BUSY;
        end else if (w_out_hs) begin
            r_state <= EMPTY;
        end
    end
`endif

    pipe_skid_entry #(
        .CTRL_WIDTH    (CTRL_WIDTH),
        .PAYLOAD_WIDTH (PAYLOAD_W)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_ctrl  (w_main_ctrl),
        .i_data  (w_main_data),
        .o_valid (w_main_vld),
        .o_ctrl  (out_ctrl),
        .o_data  (out_data)
    );

    // Counts every stalled cycle, including one where a flush lands; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_main_vld && !out_ready && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid   = w_main_vld;
    assign stall_count = r_stall_cnt;

endmodule
